// File: rtl/hex_scan_pkg.sv
// rtl/hex_scan_pkg.sv - shared types and constants for the hex digit scan controller
// Contents: FSM state enum, blank segment code, digit count, the sixteen
// active-low segment codes (bit0 = a .. bit6 = g) and a leading-digit helper.
package hex_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_SCAN    = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam int         DIGITS    = 4;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   // Index of the most significant nonzero nibble; an all-zero value reports
   // digit 0 so that a lone "0" stays visible when leading blanking is on.
   function automatic logic [1:0] top_digit(input logic [15:0] v);
      logic [1:0] top;
      top = 2'd0;
      if (v[7:4]   != 4'h0) top = 2'd1;
      if (v[11:8]  != 4'h0) top = 2'd2;
      if (v[15:12] != 4'h0) top = 2'd3;
      return top;
   endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - combinational nibble to active-low seven-segment decoder
// Ports: nibble (in, 4) hex digit; seg (out, 7) active-low code, bit0 = a.
module hex7seg_dec
   import hex_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - loads a 16-bit value and scans it digit by digit onto four 7-seg outputs
// Parameter: SCAN_DIV (1..65535) clock cycles per digit slot.
// Ports: CLOCK_50 clock; Reset async active-high; load_valid/load_data/load_ready
// value handshake; busy high while capturing/scanning; HEX0..HEX3 registered
// active-low segment codes (HEX0 = load_data[3:0]).
// Build option: HEX_SCAN_BLANK_EN blanks digits above the leading nonzero nibble.
module hex_scan_ctrl
   import hex_scan_pkg::*;
#(
   parameter int SCAN_DIV = 50
)(
   input  logic        CLOCK_50,
   input  logic        Reset,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   output logic        busy,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3
);

   localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

   state_t      state, state_nxt;
   logic [1:0]  idx;
   logic [15:0] cnt;
   logic [15:0] value;
   logic [6:0]  hex_q [DIGITS];
   logic [3:0]  nibble;
   logic [6:0]  seg;
   logic [6:0]  digit_code;
   logic        slot_end;

   assign load_ready = (state == ST_IDLE) && !Reset;
   assign busy       = (state != ST_IDLE);

   assign nibble   = value[{idx, 2'b00} +: 4];
   assign slot_end = (state == ST_SCAN) && (cnt == CNT_LAST);

   hex7seg_dec u_dec (
      .nibble (nibble),
      .seg    (seg)
   );

`ifdef HEX_SCAN_BLANK_EN
   assign digit_code = (idx > top_digit(value)) ? SEG_BLANK : seg;
`else
   assign digit_code = seg;
`endif

   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (load_valid) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_SCAN;
         ST_SCAN:    if (slot_end && (idx == 2'd3)) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
         idx   <= 2'd0;
         cnt   <= 16'd0;
         value <= 16'h0000;
         for (int i = 0; i < DIGITS; i++) hex_q[i] <= SEG_BLANK;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_valid) value <= load_data;
            end
            ST_CAPTURE: begin
               idx <= 2'd0;
               cnt <= 16'd0;
            end
            ST_SCAN: begin
               if (slot_end) begin
                  hex_q[idx] <= digit_code;
                  cnt        <= 16'd0;
                  idx        <= idx + 2'd1;   // wraps 3 -> 0 on the final digit
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - self-checking bench for hex_scan_ctrl (SCAN_DIV 4 and 1 instances)
module tb_hex_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        lv4, lv1;
   logic [15:0] ld4, ld1;
   logic        lr4, bz4, lr1, bz1;
   logic [6:0]  a0, a1, a2, a3, b0, b1, b2, b3;

   int checks = 0;
   int errors = 0;

   hex_scan_ctrl #(.SCAN_DIV(4)) dut4 (
      .CLOCK_50(clk), .Reset(rst), .load_valid(lv4), .load_data(ld4),
      .load_ready(lr4), .busy(bz4), .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3));

   hex_scan_ctrl #(.SCAN_DIV(1)) dut1 (
      .CLOCK_50(clk), .Reset(rst), .load_valid(lv1), .load_data(ld1),
      .load_ready(lr1), .busy(bz1), .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3));

   localparam logic [6:0] CODE [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int divs [2] = '{4, 1};

   // Model: a transfer at edge t0 makes digit n appear at edge t0+(n+1)*D+1
   // and the block accepts again after edge t0+4*D+1.
   int          cyc;
   bit          act [2];
   int          t0 [2];
   logic [15:0] mv [2];
   logic [6:0]  mh [2][4];

   function automatic logic [6:0] exp_code(input logic [15:0] v, input int n);
`ifdef HEX_SCAN_BLANK_EN
      int top;
      top = 0;
      for (int k = 0; k < 4; k++) if (((v >> (4 * k)) & 16'hF) != 0) top = k;
      if (n > top) return 7'h7F;
`endif
      return CODE[(v >> (4 * n)) & 16'hF];
   endfunction

   function automatic logic [6:0] dut_hex(input int i, input int n);
      logic [6:0] r;
      case (n)
         0: r = (i == 0) ? a0 : b0;
         1: r = (i == 0) ? a1 : b1;
         2: r = (i == 0) ? a2 : b2;
         default: r = (i == 0) ? a3 : b3;
      endcase
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0;
         for (int n = 0; n < 4; n++) mh[i][n] = 7'h7F;
      end
   endtask

   initial begin
      cyc = 0;
      model_clear();
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_clear();
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (act[i]) begin
               for (int n = 0; n < 4; n++)
                  if (cyc == t0[i] + (n + 1) * divs[i] + 1) mh[i][n] = exp_code(mv[i], n);
               if (cyc == t0[i] + 4 * divs[i] + 1) act[i] = 1'b0;
            end else if ((i == 0) ? lv4 : lv1) begin
               act[i] = 1'b1;
               t0[i]  = cyc;
               mv[i]  = (i == 0) ? ld4 : ld1;
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("ready4", lr4, !act[0] && !rst);
         chk("busy4",  bz4, act[0]);
         chk("ready1", lr1, !act[1] && !rst);
         chk("busy1",  bz1, act[1]);
         for (int i = 0; i < 2; i++)
            for (int n = 0; n < 4; n++)
               chk($sformatf("hex%0d_dut%0d", n, i), dut_hex(i, n), mh[i][n]);
      end
   end

   task automatic do_load(input int i, input logic [15:0] d);
      @(negedge clk);
      if (i == 0) begin lv4 = 1'b1; ld4 = d; end
      else        begin lv1 = 1'b1; ld1 = d; end
      @(posedge clk);
      #1;
      if (i == 0) lv4 = 1'b0; else lv1 = 1'b0;
   endtask

   task automatic after_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; lv4 = 1'b0; lv1 = 1'b0; ld4 = 16'h0; ld1 = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_hold_ready", lr4, 1'b0);
      chk("rst_hold_busy",  bz4, 1'b0);
      rst = 1'b0;
      after_edge();
      chk("reset_ready", lr4, 1'b1);
      chk("reset_busy",  bz4, 1'b0);
      chk("reset_hex0",  a0, 7'h7F);
      chk("reset_hex3",  a3, 7'h7F);

      // 1234 at SCAN_DIV=4: digits at edges 5, 9, 13, 17
      do_load(0, 16'h1234);
      for (int c = 1; c <= 17; c++) begin
         after_edge();
         if (c == 4)  chk("l1234_hex0_before", a0, 7'h7F);
         if (c == 5)  chk("l1234_hex0", a0, 7'h19);
         if (c == 9)  chk("l1234_hex1", a1, 7'h30);
         if (c == 13) chk("l1234_hex2", a2, 7'h24);
         if (c == 16) chk("l1234_ready_early", lr4, 1'b0);
         if (c == 17) begin
            chk("l1234_hex3", a3, 7'h79);
            chk("l1234_ready", lr4, 1'b1);
         end
      end

      // ABCD, then FFFF offered for the whole scan must be ignored
      do_load(0, 16'hABCD);
      lv4 = 1'b1; ld4 = 16'hFFFF;
      for (int c = 1; c <= 17; c++) @(posedge clk);
      @(negedge clk);
      lv4 = 1'b0;
      chk("abcd_hex3", a3, 7'h08);
      chk("abcd_hex2", a2, 7'h03);
      chk("abcd_hex1", a1, 7'h46);
      chk("abcd_hex0", a0, 7'h21);
      after_edge();
      chk("abcd_no_ffff", a0, 7'h21);

      // 8E0F aborted by reset after edge 10
      do_load(0, 16'h8E0F);
      for (int c = 1; c <= 10; c++) after_edge();
      chk("8e0f_hex1_written", a1, 7'h40);
      rst = 1'b1;
      #1;
      chk("abort_hex0", a0, 7'h7F);
      chk("abort_hex1", a1, 7'h7F);
      chk("abort_busy", bz4, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready", lr4, 1'b1);
      do_load(0, 16'h0000);
      for (int c = 1; c <= 17; c++) after_edge();
      chk("zero_hex0", a0, 7'h40);
`ifdef HEX_SCAN_BLANK_EN
      chk("zero_hex1", a1, 7'h7F);
      chk("zero_hex3", a3, 7'h7F);
`else
      chk("zero_hex1", a1, 7'h40);
      chk("zero_hex3", a3, 7'h40);
`endif

      do_load(0, 16'h0050);
      for (int c = 1; c <= 17; c++) after_edge();
      chk("h0050_hex0", a0, 7'h40);
      chk("h0050_hex1", a1, 7'h12);
`ifdef HEX_SCAN_BLANK_EN
      chk("h0050_hex2", a2, 7'h7F);
      chk("h0050_hex3", a3, 7'h7F);
`else
      chk("h0050_hex2", a2, 7'h40);
      chk("h0050_hex3", a3, 7'h40);
`endif

      // SCAN_DIV=1: one digit per cycle, idle again 5 edges after transfer
      do_load(1, 16'hFFFF);
      for (int c = 1; c <= 5; c++) begin
         after_edge();
         if (c == 2) chk("d1_hex0", b0, 7'h0E);
         if (c == 4) chk("d1_busy", bz1, 1'b1);
         if (c == 5) begin
            chk("d1_idle",  lr1, 1'b1);
            chk("d1_hex3",  b3, 7'h0E);
         end
      end

      // Random traffic on both instances, one reset pulse in the middle
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         lv4 = ($urandom_range(0, 2) == 0);
         ld4 = 16'($urandom);
         lv1 = ($urandom_range(0, 2) == 0);
         ld1 = 16'($urandom);
         rst = (k == 300 || k == 301);
      end
      @(negedge clk);
      lv4 = 1'b0; lv1 = 1'b0; rst = 1'b0;
      repeat (20) after_edge();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50, clock cycles spent on each digit slot (legal range 1..65535).
REQ-002 SHALL provide port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port load_valid  input  1  requester offers a new 16-bit value.
REQ-005 SHALL provide port load_data  input  16  four hex nibbles; [3:0] maps to HEX0, [15:12] maps to HEX3.
REQ-006 SHALL provide port load_ready  output  1  high only in IDLE; a transfer occurs when load_valid and load_ready are both high on a clock edge.
REQ-007 SHALL provide port busy  output  1  high in CAPTURE and SCAN.
REQ-008 SHALL provide ports HEX0, HEX1, HEX2, HEX3  output  7 each  registered active-low segment codes; bit0 is segment a and bit6 is segment g.

Function
REQ-009 SHALL implement a three-state FSM with states IDLE, CAPTURE and SCAN.
REQ-010 SHALL move IDLE->CAPTURE on a transfer, latching load_data into an internal 16-bit value register.
REQ-011 SHALL move CAPTURE->SCAN after exactly one cycle, clearing the digit index to 0 and the slot counter to 0.
REQ-012 In SCAN, SHALL drive the nibble selected by the digit index through one shared decoder instance.
REQ-013 In SCAN, SHALL increment the slot counter each cycle; when it reaches SCAN_DIV-1, SHALL write the decoder output into HEX[index], clear the counter and increment the index.
REQ-014 SHALL move SCAN->IDLE on the cycle HEX3 is written; the index wraps from 3 to 0.
REQ-015 Latency SHALL be: HEXn updated at (n+1)*SCAN_DIV+1 cycles after the transfer edge; load_ready reasserts on the cycle after the HEX3 write.
REQ-016 While busy, SHALL ignore load_valid and hold load_data unsampled; no queuing.
REQ-017 SHALL hold each HEXn at its previous value until that digit is rewritten; no intermediate glitch values.
REQ-018 With SCAN_DIV=1, SHALL write one digit per cycle, for a total of 5 cycles from transfer to the return to IDLE.
REQ-019 SHALL use decoder codes 0-F of 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, active-low).

Reset
REQ-020 Reset asserted SHALL immediately force state=IDLE, index=0, counter=0, value=0000, and HEX0-HEX3=7F (blank).
REQ-021 While Reset is asserted, SHALL hold load_ready=0 and busy=0.
REQ-022 SHALL drive load_ready=1 from the first clock edge after Reset deasserts.
REQ-023 Reset asserted mid-SCAN SHALL abort the scan and blank all digits, including those already written.

Configuration
REQ-024 SHALL support macro HEX_SCAN_BLANK_EN.
REQ-025 When HEX_SCAN_BLANK_EN is defined, SHALL write 7F for every digit above the most significant nonzero nibble.
REQ-026 When HEX_SCAN_BLANK_EN is defined and value=0000, SHALL show HEX0=40 and HEX1-HEX3=7F.
REQ-027 When HEX_SCAN_BLANK_EN is undefined, SHALL decode all four digits; timing SHALL be identical in both builds.

Structure
REQ-028 SHALL place the FSM state enum, the blank code 7F, the digit count 4 and the 16 segment-code constants in package hex_scan_pkg.
REQ-029 SHALL place the combinational nibble-to-segment decoder in sub-module hex7seg_dec, instantiated exactly once.

Verification
REQ-030 SHALL cover: reset -> HEX0-HEX3=7F, load_ready=1, busy=0.
REQ-031 SHALL cover: SCAN_DIV=4, load 1234 -> HEX0=19 at cycle 5, HEX1=30 at 9, HEX2=24 at 13, HEX3=79 at 17; load_ready high at 18.
REQ-032 SHALL cover: load ABCD, then load_valid held with data FFFF during the scan -> final HEX3..HEX0=08,03,46,21; FFFF never displayed.
REQ-033 SHALL cover: SCAN_DIV=4, load 8E0F, Reset pulsed at cycle 10 -> all digits 7F, FSM IDLE; the next load of 0000 completes normally.
REQ-034 SHALL cover, with HEX_SCAN_BLANK_EN: load 0050 -> HEX0=40, HEX1=12, HEX2=7F, HEX3=7F; load 0000 -> HEX0=40, others 7F.
REQ-035 SHALL cover: SCAN_DIV=1, load FFFF -> all digits 0E; back to IDLE 5 cycles after the transfer.
